// File: rtl/spdif_subframe_sequencer.sv
// rtl/spdif_subframe_sequencer.sv - S/PDIF preamble lock, subframe bit gating and block error handling
module spdif_subframe_sequencer #(
  parameter int SUBFRAME_BITS    = 28,
  parameter int FRAMES_PER_BLOCK = 192,
  parameter int SYNC_TIMEOUT     = 64,
  parameter int ERR_W            = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_v,
  input  logic             bit_d,
  input  logic             sync_v,
  input  logic [1:0]       sync_type,
  output logic             dm_vin,
  output logic             dm_din,
  output logic [7:0]       dm_frame_counter,
  output logic             dm_in_channel,
  output logic             dm_rst,
  input  logic             dm_done,
  input  logic             dm_kill,
  output logic             locked,
  output logic             block_ok,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int BC_W = $clog2(SUBFRAME_BITS + 1);
  localparam int TO_W = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [BC_W-1:0] BC_LAST    = BC_W'(SUBFRAME_BITS - 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(SYNC_TIMEOUT - 1);
  localparam logic [7:0]      FRAME_LAST = 8'(FRAMES_PER_BLOCK - 1);
  localparam logic [1:0]      PRE_B      = 2'd0;
  localparam logic [1:0]      PRE_M      = 2'd1;
  localparam logic [1:0]      PRE_W      = 2'd2;

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    PASS      = 2'd1,
    WAIT_SYNC = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [BC_W-1:0] bit_cnt;
  logic [BC_W-1:0] bit_cnt_n;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_n;
  logic [7:0]      frame_n;
  logic            ch_n;
  logic            done_q;
  logic            dm_rst_q;
  logic            done_rise;
  logic            crc_err;
  logic            crc_ok;
  logic            seq_err;
  logic            err_any;
  logic            fwd;
  logic [1:0]      exp_type;

  // A block result is only meaningful while a block is being tracked
  assign done_rise = dm_done & ~done_q;
  assign crc_err   = done_rise &  dm_kill & (state != HUNT);
  assign crc_ok    = done_rise & ~dm_kill & (state != HUNT);
  assign err_any   = seq_err | crc_err;

  // Preamble that must follow the subframe just passed: A->W, B->M, last B of block->B
  assign exp_type = !dm_in_channel ? PRE_W :
                    (dm_frame_counter == FRAME_LAST) ? PRE_B : PRE_M;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: preamble tracking, bit counting, sync timeout and error detection
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    to_cnt_n  = to_cnt;
    frame_n   = dm_frame_counter;
    ch_n      = dm_in_channel;
    seq_err   = 1'b0;
    fwd       = 1'b0;
    case (state)
      HUNT: begin
        if (sync_v && (sync_type == PRE_B)) begin
          frame_n   = 8'd0;
          ch_n      = 1'b0;
          bit_cnt_n = '0;
          state_n   = PASS;
        end
      end
      PASS: begin
        if (sync_v) begin
          seq_err = 1'b1;
        end else if (bit_v) begin
          fwd       = 1'b1;
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == BC_LAST) begin
            to_cnt_n = '0;
            state_n  = WAIT_SYNC;
          end
        end
      end
      WAIT_SYNC: begin
        if (sync_v) begin
          if (sync_type == exp_type) begin
            bit_cnt_n = '0;
            state_n   = PASS;
            if (!dm_in_channel) begin
              ch_n = 1'b1;
            end else begin
              ch_n    = 1'b0;
              frame_n = (dm_frame_counter == FRAME_LAST) ? 8'd0 : dm_frame_counter + 8'd1;
            end
          end else begin
            seq_err = 1'b1;
          end
        end else if (bit_v) begin
          to_cnt_n = to_cnt + 1'b1;
          if (to_cnt == TO_LAST) begin
            seq_err = 1'b1;
          end
        end
      end
      default: state_n = HUNT;
    endcase
    if (seq_err || crc_err) begin
      state_n = HUNT;
    end
  end

  // Datapath: counters, frame/channel on accepted sync only, registered strobes and error count
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt          <= '0;
      to_cnt           <= '0;
      dm_frame_counter <= 8'd0;
      dm_in_channel    <= 1'b0;
      dm_vin           <= 1'b0;
      dm_din           <= 1'b0;
      done_q           <= 1'b0;
      dm_rst_q         <= 1'b0;
      block_ok         <= 1'b0;
      err_pulse        <= 1'b0;
      err_count        <= '0;
    end else begin
      bit_cnt   <= bit_cnt_n;
      to_cnt    <= to_cnt_n;
      if (!err_any) begin
        dm_frame_counter <= frame_n;
        dm_in_channel    <= ch_n;
      end
      dm_vin    <= fwd & ~crc_err;
      dm_din    <= fwd & ~crc_err & bit_d;
      done_q    <= dm_done;
      dm_rst_q  <= err_any;
      block_ok  <= crc_ok;
      err_pulse <= err_any;
      if (err_any && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  // Outputs: lock follows state; dismantler held in reset throughout rst as well
  always_comb begin
    locked = (state != HUNT);
    dm_rst = rst | dm_rst_q;
  end

endmodule

// File: tb/tb_spdif_subframe_sequencer.sv
// tb/tb_spdif_subframe_sequencer.sv - vector table, directed sequences and random run against a subframe-index model
module tb_spdif_subframe_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_v = 1'b0;
  logic       bit_d = 1'b0;
  logic       sync_v = 1'b0;
  logic [1:0] sync_type = 2'd0;
  logic       dm_done = 1'b0;
  logic       dm_kill = 1'b0;
  logic       dm_vin, dm_din, dm_in_channel, dm_rst, locked, block_ok, err_pulse;
  logic [7:0] dm_frame_counter;
  logic [7:0] err_count;
  logic       s_vin, s_din, s_ch, s_rst, s_locked, s_ok, s_err;
  logic [7:0] s_frame;
  logic [1:0] err_count2;

  int errors = 0;
  int checks = 0;
  int vin_cnt = 0;

  spdif_subframe_sequencer u_dut (
    .clk(clk), .rst(rst), .bit_v(bit_v), .bit_d(bit_d), .sync_v(sync_v), .sync_type(sync_type),
    .dm_vin(dm_vin), .dm_din(dm_din), .dm_frame_counter(dm_frame_counter), .dm_in_channel(dm_in_channel),
    .dm_rst(dm_rst), .dm_done(dm_done), .dm_kill(dm_kill), .locked(locked), .block_ok(block_ok),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  spdif_subframe_sequencer #(.ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .bit_v(bit_v), .bit_d(bit_d), .sync_v(sync_v), .sync_type(sync_type),
    .dm_vin(s_vin), .dm_din(s_din), .dm_frame_counter(s_frame), .dm_in_channel(s_ch),
    .dm_rst(s_rst), .dm_done(dm_done), .dm_kill(dm_kill), .locked(s_locked), .block_ok(s_ok),
    .err_pulse(s_err), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  // Reference model: position is a linear subframe index 0..383 within the block
  bit   m_locked;
  bit   m_dprev;
  int   m_p, m_nb, m_wait, m_errs;
  logic e_vin, e_din, e_ok, e_err, e_dmrst;

  function automatic logic [1:0] pre_for(input int s);
    if (s % 384 == 0) return 2'd0;
    else if (s % 2 == 1) return 2'd2;
    else return 2'd1;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input logic r, bv, bd, sv, input logic [1:0] st, input logic dn, kl);
    bit err;
    bit rise;
    if (r) begin
      m_locked = 0; m_dprev = 0; m_p = 0; m_nb = 0; m_wait = 0; m_errs = 0;
      e_vin = 0; e_din = 0; e_ok = 0; e_err = 0; e_dmrst = 1;
      return;
    end
    err = 0; e_ok = 0; e_vin = 0; e_din = 0;
    rise = dn && !m_dprev;
    m_dprev = dn;
    if (m_locked && rise) begin
      if (kl) err = 1;
      else e_ok = 1;
    end
    if (!m_locked) begin
      if (sv && st == 2'd0) begin
        m_locked = 1; m_p = 0; m_nb = 0;
      end
    end else if (m_nb < 28) begin
      if (sv) err = 1;
      else if (bv) begin
        e_vin = 1; e_din = bd; m_nb++;
        if (m_nb == 28) m_wait = 0;
      end
    end else begin
      if (sv) begin
        if (st == pre_for(m_p + 1)) begin
          if (!err) begin m_p = (m_p + 1) % 384; m_nb = 0; end
        end else err = 1;
      end else if (bv) begin
        m_wait++;
        if (m_wait == 64) err = 1;
      end
    end
    if (err) begin
      m_locked = 0; m_errs++; e_vin = 0; e_din = 0;
    end
    e_err = err;
    e_dmrst = err;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge and compare everything
  task automatic cyc(input logic bv, bd, sv, input logic [1:0] st, input logic dn, kl, r);
    bit_v = bv; bit_d = bd; sync_v = sv; sync_type = st; dm_done = dn; dm_kill = kl; rst = r;
    model_step(r, bv, bd, sv, st, dn, kl);
    @(posedge clk);
    #1;
    if (dm_vin === 1'b1) vin_cnt++;
    check("model", 32'({dm_vin, dm_din, dm_frame_counter, dm_in_channel, dm_rst, block_ok, err_pulse,
                        locked, err_count, err_count2}),
                   32'({e_vin, e_din, 8'(m_p / 2), 1'(m_p % 2), e_dmrst, e_ok, e_err,
                        1'(m_locked), 8'(sat(m_errs, 255)), 2'(sat(m_errs, 3))}));
  endtask

  task automatic idle();
    cyc(0, 0, 0, 2'd0, 0, 0, 0);
  endtask

  task automatic sync(input logic [1:0] t);
    cyc(0, 0, 1, t, 0, 0, 0);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) idle();
      cyc(1, 1'($urandom_range(0, 1)), 0, 2'd0, 0, 0, 0);
    end
  endtask

  typedef struct packed {
    logic       r, bv, bd, sv;
    logic [1:0] st;
    logic       dn, kl;
    logic [5:0] exp;   // {dm_vin, dm_din, locked, err_pulse, block_ok, dm_rst}
  } vec_t;

  vec_t tbl [20];
  logic dn_r;
  logic bv_r, sv_r;
  logic [1:0] st_r;

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 2'd0, 0, 0, 6'b000001};
    tbl[1]  = '{0, 1, 1, 0, 2'd0, 0, 0, 6'b000000};
    tbl[2]  = '{0, 0, 0, 1, 2'd1, 0, 0, 6'b000000};
    tbl[3]  = '{0, 0, 0, 1, 2'd0, 0, 0, 6'b001000};
    tbl[4]  = '{0, 1, 1, 0, 2'd0, 0, 0, 6'b111000};
    tbl[5]  = '{0, 1, 0, 0, 2'd0, 0, 0, 6'b101000};
    tbl[6]  = '{0, 0, 0, 0, 2'd0, 0, 0, 6'b001000};
    tbl[7]  = '{0, 1, 1, 1, 2'd2, 0, 0, 6'b000101};
    tbl[8]  = '{0, 1, 1, 0, 2'd0, 0, 0, 6'b000000};
    tbl[9]  = '{0, 0, 0, 1, 2'd2, 0, 0, 6'b000000};
    tbl[10] = '{0, 0, 0, 1, 2'd0, 0, 0, 6'b001000};
    tbl[11] = '{0, 1, 1, 0, 2'd0, 0, 0, 6'b111000};
    tbl[12] = '{0, 0, 0, 0, 2'd0, 1, 0, 6'b001010};
    tbl[13] = '{0, 0, 0, 0, 2'd0, 1, 0, 6'b001000};
    tbl[14] = '{0, 0, 0, 0, 2'd0, 0, 0, 6'b001000};
    tbl[15] = '{0, 0, 0, 0, 2'd0, 1, 1, 6'b000101};
    tbl[16] = '{0, 0, 0, 1, 2'd0, 0, 0, 6'b001000};
    tbl[17] = '{0, 1, 0, 0, 2'd0, 1, 0, 6'b101010};
    tbl[18] = '{1, 0, 0, 0, 2'd0, 0, 0, 6'b000001};
    tbl[19] = '{0, 0, 0, 0, 2'd0, 0, 0, 6'b000000};

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].bv, tbl[i].bd, tbl[i].sv, tbl[i].st, tbl[i].dn, tbl[i].kl, tbl[i].r);
      check($sformatf("vec%0d", i), 32'({dm_vin, dm_din, locked, err_pulse, block_ok, dm_rst}), 32'(tbl[i].exp));
    end
    check("vec_cnt_after_rst", 32'(err_count), 32'd0);

    // Clean block: 384 subframes, then CRC ok while waiting for the closing B
    vin_cnt = 0;
    for (int s = 0; s < 384; s++) begin
      sync(pre_for(s));
      check($sformatf("frame_s%0d", s), 32'(dm_frame_counter), 32'(s / 2));
      check($sformatf("chan_s%0d", s), 32'(dm_in_channel), 32'(s % 2));
      send_bits(28);
    end
    check("clean_strobes", 32'(vin_cnt), 32'd10752);
    check("clean_locked", 32'(locked), 32'd1);
    cyc(0, 0, 0, 2'd0, 1, 0, 0);
    check("crc_ok_pulse", 32'(block_ok), 32'd1);
    cyc(0, 0, 0, 2'd0, 1, 0, 0);
    check("crc_ok_once", 32'(block_ok), 32'd0);
    idle();
    sync(2'd0);
    check("wrap_frame", 32'({dm_frame_counter, dm_in_channel, locked}), 32'({8'd0, 1'b0, 1'b1}));
    cyc(0, 0, 0, 2'd0, 1, 1, 0);
    check("crc_kill", 32'({dm_rst, err_pulse, locked, err_count}), 32'({1'b1, 1'b1, 1'b0, 8'd1}));
    idle();
    check("crc_kill_end", 32'({dm_rst, err_pulse}), 32'd0);

    // Wrong order: M where W is expected after frame 5 channel A
    sync(2'd0);
    for (int s = 0; s < 10; s++) begin
      send_bits(28);
      sync(pre_for(s + 1));
    end
    check("order_pos", 32'({dm_frame_counter, dm_in_channel}), 32'({8'd5, 1'b0}));
    send_bits(28);
    sync(2'd1);
    check("order_err", 32'({err_pulse, locked, err_count}), 32'({1'b1, 1'b0, 8'd2}));
    vin_cnt = 0;
    send_bits(28);
    sync(2'd2);
    send_bits(5);
    check("order_no_vin", 32'(vin_cnt), 32'd0);
    check("order_hunt", 32'(locked), 32'd0);

    // Premature preamble after 10 bits
    sync(2'd0);
    send_bits(10);
    sync(2'd2);
    check("premature", 32'({err_pulse, dm_rst, locked, err_count}), 32'({1'b1, 1'b1, 1'b0, 8'd3}));

    // Timeout: 64th bit strobe in WAIT_SYNC
    sync(2'd0);
    send_bits(28);
    for (int i = 0; i < 63; i++) cyc(1, 1, 0, 2'd0, 0, 0, 0);
    check("timeout_63", 32'({err_pulse, locked}), 32'({1'b0, 1'b1}));
    cyc(1, 1, 0, 2'd0, 0, 0, 0);
    check("timeout_64", 32'({err_pulse, locked, err_count}), 32'({1'b1, 1'b0, 8'd4}));

    // Fifth error: narrow counter saturates
    sync(2'd0);
    send_bits(3);
    sync(2'd1);
    check("sat_narrow", 32'(err_count2), 32'd3);
    check("sat_wide", 32'(err_count), 32'd5);

    // Reset in the middle of a subframe at frame 1
    sync(2'd0); send_bits(28);
    sync(2'd2); send_bits(28);
    sync(2'd1); send_bits(5);
    check("pre_rst_frame", 32'(dm_frame_counter), 32'd1);
    cyc(1, 1, 0, 2'd0, 0, 0, 1);
    check("rst_outputs", 32'({dm_vin, dm_din, dm_frame_counter, dm_in_channel, dm_rst, block_ok, err_pulse, locked, err_count}),
                         32'({1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
    cyc(1, 1, 0, 2'd0, 0, 0, 1);
    check("rst_hold", 32'({dm_vin, dm_rst}), 32'({1'b0, 1'b1}));
    cyc(1, 1, 0, 2'd0, 0, 0, 0);
    check("rst_release", 32'({dm_vin, dm_rst, locked}), 32'd0);

    // Random run, biased toward legal preamble order
    dn_r = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      bv_r = ($urandom_range(0, 9) < 7);
      st_r = 2'($urandom_range(0, 3));
      if (!m_locked) begin
        sv_r = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 1) == 0) st_r = 2'd0;
      end else if (m_nb >= 28) begin
        sv_r = ($urandom_range(0, 99) < 35);
        if ($urandom_range(0, 9) < 8) st_r = pre_for(m_p + 1);
      end else begin
        sv_r = ($urandom_range(0, 199) == 0);
      end
      if ($urandom_range(0, 29) == 0) dn_r = ~dn_r;
      cyc(bv_r, 1'($urandom_range(0, 1)), sv_r, st_r, dn_r, 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 999) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spdif_subframe_sequencer.md
# spdif_subframe_sequencer

Sequencer between the optical-link line decoder and the subframe dismantler. It locks onto the block-start preamble and gates the 28 post-preamble bits of each subframe into the dismantler. It generates the dismantler's frame index (0..191) and channel select, and checks the preamble order. On sync loss or block CRC failure it resets the dismantler and counts the error.

## Interface
Parameters:
- SUBFRAME_BITS, 28, payload bits per subframe after the preamble (4 aux, 20 data, V, U, C, P).
- FRAMES_PER_BLOCK, 192, frames per channel-status block.
- SYNC_TIMEOUT, 64, bit_v strobes tolerated in WAIT_SYNC before lock is declared lost.
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- bit_v  in  1  one decoded payload bit is present this cycle.
- bit_d  in  1  payload bit value.
- sync_v  in  1  one-cycle pulse: a preamble has just completed.
- sync_type  in  2  preamble type, valid with sync_v: 0 = B (block start, ch A), 1 = M (ch A), 2 = W (ch B), 3 = illegal.
- dm_vin  out  1  bit strobe to the dismantler.
- dm_din  out  1  bit to the dismantler.
- dm_frame_counter  out  8  current frame index, 0..FRAMES_PER_BLOCK-1.
- dm_in_channel  out  1  0 = channel A, 1 = channel B.
- dm_rst  out  1  dismantler reset.
- dm_done  in  1  dismantler block-complete level.
- dm_kill  in  1  dismantler CRC-failure level, valid with dm_done.
- locked  out  1  sequencer is tracking a block.
- block_ok  out  1  one-cycle pulse: block completed with good CRC.
- err_pulse  out  1  one-cycle pulse per detected error.
- err_count  out  ERR_W  saturating error count.

## Operation
States:
- HUNT
  - locked = 0.
  - sync_v with type B: frame = 0, ch = 0, bit_cnt = 0, locked = 1, go to PASS.
  - All other syncs and all bits are ignored.
- PASS
  - Each bit_v: dm_vin = 1 and dm_din = bit_d on the next cycle, bit_cnt++.
  - After the SUBFRAME_BITS-th bit: go to WAIT_SYNC, to_cnt = 0.
  - sync_v in PASS (premature preamble) is an error.
- WAIT_SYNC
  - bit_v is not forwarded; each bit_v increments to_cnt.
  - to_cnt reaching SYNC_TIMEOUT is an error.
  - Expected preamble:
    - ch = 0: W. Then ch = 1, frame unchanged.
    - ch = 1 and frame < FRAMES_PER_BLOCK-1: M. Then ch = 0, frame + 1.
    - ch = 1 and frame = FRAMES_PER_BLOCK-1: B. Then ch = 0, frame = 0.
  - Matching sync: bit_cnt = 0, go to PASS.
  - Mismatched or illegal type: error.

Error action (single cycle):
- dm_rst = 1 for one cycle.
- err_pulse = 1; err_count + 1, holding at all-ones.
- locked = 0; go to HUNT.
- A B preamble that triggers the error is consumed; the sequencer relocks on the next B.

Block result:
- On the rising edge of dm_done, the dismantler result is checked.
- dm_kill = 1: error action.
- dm_kill = 0: block_ok pulse. The state is unchanged.
- A dm_done rising edge seen in HUNT is ignored.

Other rules:
- dm_frame_counter and dm_in_channel update only on sync acceptance, so they are stable for all dm_vin strobes of a subframe.
- If sync_v and bit_v are both high in one cycle, the sync is processed and the bit is dropped.

## Timing
- dm_vin and dm_din are registered: one-cycle latency from bit_v and bit_d.
- dm_frame_counter and dm_in_channel are valid the cycle after the accepting sync_v, before the first dm_vin.
- Error detection to dm_rst and err_pulse: one cycle.
- Rising edge of dm_done to block_ok or err_pulse: one cycle.
- Reset values:
  - State HUNT.
  - dm_rst = 1 during rst, 0 on the first cycle after rst is released.
  - All other outputs 0.
  - err_count = 0.
- rst asserted mid-subframe: no further dm_vin; the next cycle starts in HUNT.

## Test plan
- Clean block: B, 28 bits, W, 28 bits, then M/W pairs up to frame 191, then B. Required:
  - Exactly 192×2×28 dm_vin strobes.
  - dm_frame_counter steps 0..191.
  - dm_in_channel alternates 0/1.
  - The final B restarts at frame 0 with locked held at 1.
- CRC result: after the last W subframe, drive dm_done = 1 with dm_kill = 0. Required: block_ok for one cycle.
  - Repeat with dm_kill = 1. Required: dm_rst and err_pulse pulse, err_count = 1, locked = 0.
- Wrong order: at frame 5 ch A, send M instead of W. Required: err_pulse, state HUNT; following bits produce no dm_vin until the next B.
- Premature sync: sync_v after 10 bits of a subframe. Required: error, err_count increments.
- Timeout: in WAIT_SYNC, 64 bit_v strobes with no sync. Required: err_pulse on the 64th strobe, locked = 0.
- Saturation and reset:
  - With ERR_W = 2, inject 5 errors. Required: err_count = 3.
  - Assert rst mid-PASS. Required: all outputs at reset values, dm_rst = 1 while rst is high.
